// File: rtl/trng_pool_pkg.sv
// Shared constants for the entropy pool: FSM encodings and default sizes.
package trng_pool_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_FAIL = 2'd3;

  localparam int TRNG_WORD_W    = 32;
  localparam int TRNG_RCT_LIMIT = 32;

endpackage

// File: rtl/trng.sv
// Ring-oscillator entropy cell, cycle-based model. Each instance is offset by
// trng_delay so the cells start out of phase; oscillation stops while rst_n
// is low or en is low.
module trng #(
  parameter int trng_delay = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic rnd_bit
);

  localparam logic [15:0] SEED = 16'h0001 << (trng_delay % 16);

  logic [15:0] lfsr;
  logic        fb;

  assign fb      = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign rnd_bit = lfsr[15];

  // free-running oscillator state, parked at its seed during reset
  always_ff @(posedge clk) begin
    if (!rst_n)  lfsr <= SEED;
    else if (en) lfsr <= {lfsr[14:0], fb};
  end

endmodule

// File: rtl/trng_vn_debias.sv
// Von Neumann debiaser: latches the first bit of a pair, then emits the first
// bit when the pair differs (01 -> 0, 10 -> 1) or flags a drop when equal.
// Driving rst also discards a half-collected pair.
module trng_vn_debias (
  input  logic clk,
  input  logic rst,
  input  logic in_vld,
  input  logic in_bit,
  output logic out_vld,
  output logic out_bit,
  output logic drop
);

  logic have;
  logic first;

  assign out_vld = in_vld & have & (first != in_bit);
  assign out_bit = first;
  assign drop    = in_vld & have & (first == in_bit);

  // pair latch: alternate between capturing the first bit and resolving the pair
  always_ff @(posedge clk) begin
    if (rst) begin
      have  <= 1'b0;
      first <= 1'b0;
    end else if (in_vld) begin
      if (!have) begin
        first <= in_bit;
        have  <= 1'b1;
      end else begin
        have  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/trng_pool.sv
// Entropy pool: XOR of NUM_CH oscillator cells, synchronised, health-tested,
// optionally von Neumann debiased and packed LSB-first into WORD_W words
// delivered on a valid/ready handshake.
module trng_pool
  import trng_pool_pkg::*;
#(
  parameter int NUM_CH    = 15,
  parameter int WORD_W    = TRNG_WORD_W,
  parameter int DEBIAS    = 1,
  parameter int RCT_LIMIT = TRNG_RCT_LIMIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              test_mode,
  input  logic              test_bit,
  input  logic              clr_fail,
  output logic              rnd_valid,
  input  logic              rnd_ready,
  output logic [WORD_W-1:0] rnd_data,
  output logic              health_fail,
  output logic [15:0]       bits_dropped
);

  localparam int CNT_W = $clog2(WORD_W) + 1;
  localparam int RCT_W = $clog2(RCT_LIMIT + 1);

  logic [NUM_CH-1:0] osc;
  logic              rst_n;
  logic              pool;
  logic              sync1, sync2;
  logic              tb_q, en_q;
  logic              raw, smp_vld;
  logic [RCT_W-1:0]  rct_cnt;
  logic              rct_last;
  logic              trip;
  logic [1:0]        state;
  logic [CNT_W-1:0]  bit_cnt;
  logic              fill_vld, hold_drop;
  logic              acc_vld, acc_bit, vn_drop;
  logic              pair_rst;

  assign rst_n = ~rst;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_osc
    trng #(.trng_delay(i)) u_trng (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .rnd_bit (osc[i])
    );
  end

  assign pool = ^osc;

  // pool synchroniser plus the single-flop test-bit path; en_q marks raw as valid
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      tb_q  <= 1'b0;
      en_q  <= 1'b0;
    end else begin
      sync1 <= pool;
      sync2 <= sync1;
      tb_q  <= test_bit;
      en_q  <= en;
    end
  end

  assign raw     = test_mode ? tb_q : sync2;
  assign smp_vld = en & en_q;
  assign trip    = (rct_cnt == RCT_W'(RCT_LIMIT));

  // repetition-count health test; a trip outranks a simultaneous clr_fail
  always_ff @(posedge clk) begin
    if (rst) begin
      rct_cnt     <= '0;
      rct_last    <= 1'b0;
      health_fail <= 1'b0;
    end else begin
      if (trip)          health_fail <= 1'b1;
      else if (clr_fail) health_fail <= 1'b0;

      if (clr_fail) begin
        rct_cnt <= '0;
      end else if (smp_vld) begin
        rct_last <= raw;
        if (rct_cnt != '0 && raw == rct_last) begin
          if (!trip) rct_cnt <= rct_cnt + RCT_W'(1);
        end else begin
          rct_cnt <= RCT_W'(1);
        end
      end
    end
  end

  assign fill_vld  = smp_vld & (state == ST_FILL);
  assign hold_drop = smp_vld & (state == ST_HOLD);
  // the pair latch only survives while filling, so any exit from FILL empties it
  assign pair_rst  = rst | (state != ST_FILL);

  if (DEBIAS != 0) begin : g_vn
    trng_vn_debias u_vn (
      .clk     (clk),
      .rst     (pair_rst),
      .in_vld  (fill_vld),
      .in_bit  (raw),
      .out_vld (acc_vld),
      .out_bit (acc_bit),
      .drop    (vn_drop)
    );
  end else begin : g_raw
    assign acc_vld = fill_vld;
    assign acc_bit = raw;
    assign vn_drop = 1'b0;
  end

  // saturating count of discarded bits (equal pairs, or bits arriving in HOLD)
  always_ff @(posedge clk) begin
    if (rst)                                              bits_dropped <= '0;
    else if ((vn_drop | hold_drop) && bits_dropped != 16'hFFFF) bits_dropped <= bits_dropped + 16'd1;
  end

  // word assembly FSM; the completing bit raises rnd_valid on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rnd_valid <= 1'b0;
      rnd_data  <= '0;
      bit_cnt   <= '0;
    end else if (trip) begin
      state     <= ST_FAIL;
      rnd_valid <= 1'b0;
      rnd_data  <= '0;
      bit_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (en && !health_fail) state <= ST_FILL;
        ST_FILL: begin
          if (!en) begin
            state <= ST_IDLE;
          end else if (acc_vld) begin
            rnd_data[bit_cnt[CNT_W-2:0]] <= acc_bit;
            if (bit_cnt == CNT_W'(WORD_W - 1)) begin
              bit_cnt   <= '0;
              state     <= ST_HOLD;
              rnd_valid <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (rnd_ready) begin
            rnd_valid <= 1'b0;
            bit_cnt   <= '0;
            state     <= en ? ST_FILL : ST_IDLE;
          end
        end
        ST_FAIL: if (clr_fail) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trng_pool.sv
// Directed bench: one raw-packing instance and one debiasing instance share
// the stimulus; expected values are hand-derived from the injected bits.
module tb_trng_pool;

  logic        clk = 1'b0;
  logic        rst, en, test_mode, test_bit, clr_fail, rnd_ready;
  logic        valid0, valid1, hf0, hf1;
  logic [31:0] data0, data1;
  logic [15:0] drop0, drop1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  trng_pool #(.NUM_CH(15), .WORD_W(32), .DEBIAS(0), .RCT_LIMIT(32)) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .test_mode(test_mode), .test_bit(test_bit),
    .clr_fail(clr_fail), .rnd_valid(valid0), .rnd_ready(rnd_ready),
    .rnd_data(data0), .health_fail(hf0), .bits_dropped(drop0));

  trng_pool #(.NUM_CH(15), .WORD_W(32), .DEBIAS(1), .RCT_LIMIT(32)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .test_mode(test_mode), .test_bit(test_bit),
    .clr_fail(clr_fail), .rnd_valid(valid1), .rnd_ready(rnd_ready),
    .rnd_data(data1), .health_fail(hf1), .bits_dropped(drop1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic b);
    test_bit = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; test_mode = 1'b1; test_bit = 1'b0;
    clr_fail = 1'b0; rnd_ready = 1'b0;
    repeat (3) step(1'b0);
    rst = 1'b0;
    step(1'b0);
  endtask

  initial begin
    logic [31:0] v;
    logic [9:0]  vn_bits;
    int          hs0, hs1, xseen;

    // reset and idle
    do_reset();
    check("rst_valid0", {31'd0, valid0}, 32'd0);
    check("rst_valid1", {31'd0, valid1}, 32'd0);
    check("rst_data0", data0, 32'd0);
    check("rst_hf0", {31'd0, hf0}, 32'd0);
    check("rst_drop0", {16'd0, drop0}, 32'd0);
    check("rst_drop1", {16'd0, drop1}, 32'd0);
    repeat (4) step(1'b1);
    check("idle_valid0", {31'd0, valid0}, 32'd0);

    // bypass packing: 1,0,1,0... -> 0x55555555 completes on the 33rd edge
    en = 1'b1;
    for (int i = 0; i <= 32; i++) begin
      step((i % 2) == 0);
      if (i == 31) check("pack_valid_early", {31'd0, valid0}, 32'd0);
    end
    check("pack_valid", {31'd0, valid0}, 32'd1);
    check("pack_data", data0, 32'h5555_5555);

    // backpressure: ten bits arrive while the word is held
    for (int i = 33; i <= 42; i++) step((i % 2) == 0);
    check("bp_valid", {31'd0, valid0}, 32'd1);
    check("bp_data", data0, 32'h5555_5555);
    check("bp_drop", {16'd0, drop0}, 32'd10);
    v = 32'hA5C3_0F96;
    rnd_ready = 1'b1;
    step(v[0]);
    rnd_ready = 1'b0;
    check("hs_valid", {31'd0, valid0}, 32'd0);
    check("hs_drop", {16'd0, drop0}, 32'd11);
    for (int k = 1; k < 32; k++) step(v[k]);
    check("refill_valid_early", {31'd0, valid0}, 32'd0);
    step(1'b0);
    check("refill_valid", {31'd0, valid0}, 32'd1);
    check("refill_data", data0, v);

    // von Neumann: pairs 01,10,00,11,10 -> accepted 0,1,1 and two drops
    do_reset();
    en = 1'b1;
    vn_bits = 10'b01_11_00_01_10; // bit 0 is injected first
    for (int k = 0; k < 10; k++) step(vn_bits[k]);
    step(1'b0);
    check("vn_data", data1, 32'h0000_0006);
    check("vn_drop", {16'd0, drop1}, 32'd2);
    check("vn_valid", {31'd0, valid1}, 32'd0);

    // health test: 32 consecutive ones trip on the following edge
    do_reset();
    en = 1'b1;
    for (int i = 0; i <= 32; i++) step(1'b1);
    check("rct_pre_hf0", {31'd0, hf0}, 32'd0);
    check("rct_pre_valid0", {31'd0, valid0}, 32'd1);
    check("rct_pre_drop1", {16'd0, drop1}, 32'd16);
    step(1'b1);
    check("rct_hf0", {31'd0, hf0}, 32'd1);
    check("rct_hf1", {31'd0, hf1}, 32'd1);
    check("rct_valid0", {31'd0, valid0}, 32'd0);
    step(1'b0);
    step(1'b0);
    check("rct_sticky", {31'd0, hf0}, 32'd1);
    clr_fail = 1'b1;
    step(1'b0);
    clr_fail = 1'b0;
    check("clr_hf0", {31'd0, hf0}, 32'd0);
    check("clr_hf1", {31'd0, hf1}, 32'd0);
    v = 32'h3C69_D2E1;
    for (int k = 0; k < 32; k++) step(v[k]);
    check("recover_valid_early", {31'd0, valid0}, 32'd0);
    step(1'b0);
    check("recover_valid", {31'd0, valid0}, 32'd1);
    check("recover_data", data0, v);

    // oscillator mode with a consumer that is always ready
    do_reset();
    test_mode = 1'b0; en = 1'b1; rnd_ready = 1'b1;
    hs0 = 0; hs1 = 0; xseen = 0;
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk);
      #1;
      if (valid0) hs0++;
      if (valid1) hs1++;
      if ($isunknown(data0) || $isunknown(data1)) xseen++;
    end
    check("osc_hs0", {31'd0, hs0 >= 100}, 32'd1);
    check("osc_hs1", {31'd0, hs1 >= 20}, 32'd1);
    check("osc_hf0", {31'd0, hf0}, 32'd0);
    check("osc_hf1", {31'd0, hf1}, 32'd0);
    check("osc_noX", xseen, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
